snes_gamepad_top: RTL and testbench

- Top-level SNES gamepad reader for a 100 MHz FPGA board.
- Generates the SNES controller latch and clock waveform at a 60 Hz poll rate.
- Shifts in the 16 serial button bits and shows the pressed-button state on 16 LEDs.
- Buttons on the pad are active-low; LEDs are active-high, so a lit LED means the button is pressed.

---
 rtl/snes_gamepad_if.sv | 22 ++
 rtl/snes_gamepad_top.sv | 124 ++++++++++++
 tb/tb_snes_gamepad_top.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/snes_gamepad_if.sv
// Pad-side signal bundle between the SNES gamepad reader and the board pins/LEDs.
// The master modport belongs to the reader; the slave modport is the pad/board side.
interface snes_gamepad_if;
  logic        snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [15:0] led;

  modport master (
    input  snes_data,
    output snes_latch,
    output snes_clk,
    output led
  );

  modport slave (
    output snes_data,
    input  snes_latch,
    input  snes_clk,
    input  led
  );
endinterface

// File: rtl/snes_gamepad_top.sv
// SNES gamepad reader: polls the pad with latch/clock strobes and shows the
// 16 pressed-button bits (inverted active-low data) on the LEDs once per frame.
module snes_gamepad_top #(
  parameter int POLL_CYCLES  = 1666667,
  parameter int LATCH_CYCLES = 1200,
  parameter int HALF_CYCLES  = 600
) (
  input  logic            clk,
  input  logic            rst,
  snes_gamepad_if.master  pad
);

  localparam int CNT_W = $clog2(POLL_CYCLES);

  typedef enum logic [1:0] {IDLE, LATCH, CLK_LOW, CLK_HIGH} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] poll_cnt_reg;
  logic [CNT_W-1:0] phase_cnt_reg;
  logic [3:0]       bit_idx_reg;
  logic [15:0]      shift_reg;
  logic [15:0]      led_reg;
  logic             sync1_reg;
  logic             sync2_reg;
  logic             latch_reg;
  logic             sclk_reg;

  logic poll_start;
  logic latch_done;
  logic half_done;

  assign poll_start = (poll_cnt_reg == '0);
  assign latch_done = (phase_cnt_reg == CNT_W'(LATCH_CYCLES - 1));
  assign half_done  = (phase_cnt_reg == CNT_W'(HALF_CYCLES - 1));

  // Free-running period counter; a frame may only begin when it reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt_reg <= '0;
    end else if (poll_cnt_reg == CNT_W'(POLL_CYCLES - 1)) begin
      poll_cnt_reg <= '0;
    end else begin
      poll_cnt_reg <= poll_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= pad.snes_data;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      bit_idx_reg   <= 4'd0;
      shift_reg     <= 16'hFFFF;
      led_reg       <= 16'h0000;
      latch_reg     <= 1'b0;
      sclk_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (poll_start) begin
            state_reg     <= LATCH;
            phase_cnt_reg <= '0;
            latch_reg     <= 1'b1;
            sclk_reg      <= 1'b1;
          end
        end
        LATCH: begin
          if (latch_done) begin
            state_reg     <= CLK_LOW;
            phase_cnt_reg <= '0;
            bit_idx_reg   <= 4'd0;
            latch_reg     <= 1'b0;
            sclk_reg      <= 1'b0;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        CLK_LOW: begin
          // Sample at the very end of the low phase, when the pad data is most settled.
          if (half_done) begin
            shift_reg[bit_idx_reg] <= sync2_reg;
            state_reg              <= CLK_HIGH;
            phase_cnt_reg          <= '0;
            sclk_reg               <= 1'b1;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        CLK_HIGH: begin
          if (half_done) begin
            phase_cnt_reg <= '0;
            if (bit_idx_reg == 4'd15) begin
              state_reg <= IDLE;
              led_reg   <= ~shift_reg;
            end else begin
              state_reg   <= CLK_LOW;
              bit_idx_reg <= bit_idx_reg + 4'd1;
              sclk_reg    <= 1'b0;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign pad.snes_latch = latch_reg;
  assign pad.snes_clk   = sclk_reg;
  assign pad.led        = led_reg;

endmodule

// File: tb/tb_snes_gamepad_top.sv
// Bench for snes_gamepad_top: a pad model shifts out a button pattern while a
// waveform model derived from elapsed cycles checks latch, clock and LEDs every cycle.
module tb_snes_gamepad_top;

  // Timing scaled down so several poll periods fit in a short run.
  localparam int POLL  = 3000;
  localparam int LATCH = 120;
  localparam int HALF  = 60;
  localparam int FRAME = LATCH + 32 * HALF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  snes_gamepad_if pad_if ();

  snes_gamepad_top #(
    .POLL_CYCLES (POLL),
    .LATCH_CYCLES(LATCH),
    .HALF_CYCLES (HALF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pad(pad_if)
  );

  always #5 clk = ~clk;

  // Pad model: raw active-low bits, bit 0 presented at latch fall, next on each clock rise.
  logic [15:0] pattern = 16'hFFFF;
  logic        pad_data = 1'b1;
  int          pad_idx = 16;
  logic        pad_prev_latch = 1'b0;
  logic        pad_prev_sclk = 1'b1;

  assign pad_if.snes_data = pad_data;

  always @(pad_if.snes_latch or pad_if.snes_clk) begin
    if (pad_prev_latch === 1'b1 && pad_if.snes_latch === 1'b0) begin
      pad_idx = 0;
    end else if (pad_prev_sclk === 1'b0 && pad_if.snes_clk === 1'b1 && pad_idx < 16) begin
      pad_idx = pad_idx + 1;
    end
    pad_prev_latch = pad_if.snes_latch;
    pad_prev_sclk  = pad_if.snes_clk;
    pad_data       = (pad_idx < 16) ? pattern[pad_idx] : 1'b1;
  end

  // Reference model: edges since reset release, and the LED value a completed frame leaves.
  int          edges = 0;
  logic [15:0] exp_led = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges   = 0;
      exp_led = 16'h0000;
    end else begin
      if ((edges % POLL) == FRAME) exp_led = ~pattern;
      edges = edges + 1;
    end
  end

  function automatic logic [17:0] expected_outputs();
    int   t;
    logic lat;
    logic low;
    if (edges == 0) return {1'b0, 1'b1, exp_led};
    t   = (edges - 1) % POLL;
    lat = (t < LATCH);
    low = (t >= LATCH) && (t < FRAME) && (((t - LATCH) % (2 * HALF)) < HALF);
    return {lat, ~low, exp_led};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edges);
    end else begin
      $display("ok   %s: %0h (edge %0d)", name, got, edges);
    end
  endtask

  // Edge bookkeeping filled in by the per-cycle compare branch.
  int   rise_last = -1;
  int   rise_prev = -1;
  int   fall_last = -1;
  int   led_change = -1;
  int   low_pulses = 0;
  logic seen_latch = 1'b0;
  logic seen_sclk = 1'b1;
  logic [15:0] seen_led = 16'h0000;

  task automatic goto_edge(input int target);
    int guard;
    guard = 0;
    while (edges < target && guard < 20000) begin
      @(negedge clk);
      guard = guard + 1;
    end
    if (edges < target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL goto_edge timeout: got edge %0d expected %0d", edges, target);
    end
  endtask

  initial begin
    fork
      begin : compare_loop
        logic [17:0] got;
        logic [17:0] want;
        forever begin
          @(negedge clk);
          got  = {pad_if.snes_latch, pad_if.snes_clk, pad_if.led};
          want = expected_outputs();
          checks = checks + 1;
          if (got !== want) begin
            errors = errors + 1;
            $display("FAIL cycle {latch,sclk,led}: got %0h expected %0h (edge %0d)", got, want, edges);
          end
          if (!seen_latch && pad_if.snes_latch === 1'b1) begin
            rise_prev  = rise_last;
            rise_last  = edges;
            low_pulses = 0;
          end
          if (seen_latch && pad_if.snes_latch === 1'b0) fall_last = edges;
          if (seen_sclk && pad_if.snes_clk === 1'b0) low_pulses = low_pulses + 1;
          if (pad_if.led !== seen_led) led_change = edges;
          seen_latch = pad_if.snes_latch;
          seen_sclk  = pad_if.snes_clk;
          seen_led   = pad_if.led;
        end
      end
      begin : main_seq
        repeat (4) @(negedge clk);
        check("reset_led", 32'(pad_if.led), 32'h0);
        check("reset_latch", 32'(pad_if.snes_latch), 32'h0);
        check("reset_sclk", 32'(pad_if.snes_clk), 32'h1);

        // Frame 1: buttons 0, 8 and 15 pressed.
        pattern = 16'h7EFE;
        rst = 1'b0;
        goto_edge(1);
        check("latch_rises_first_edge", 32'(pad_if.snes_latch), 32'h1);
        goto_edge(FRAME + 2);
        check("frame1_led", 32'(pad_if.led), 32'h8101);
        check("frame1_low_pulses", 32'(low_pulses), 32'd16);
        check("frame1_latch_width", 32'(fall_last - rise_last), 32'(LATCH));
        check("frame1_length", 32'(led_change - rise_last), 32'(FRAME));

        // Frame 2: pad released; led must hold until frame end.
        pattern = 16'hFFFF;
        goto_edge(POLL + FRAME);
        check("frame2_led_held", 32'(pad_if.led), 32'h8101);
        goto_edge(POLL + FRAME + 2);
        check("frame2_led", 32'(pad_if.led), 32'h0000);
        check("poll_period", 32'(rise_last - rise_prev), 32'(POLL));

        // Frame 3: data held low.
        pattern = 16'h0000;
        goto_edge(2 * POLL + FRAME + 2);
        check("frame3_led", 32'(pad_if.led), 32'hFFFF);

        // Frame 4: reset asserted while bit 8 is being clocked.
        pattern = 16'h7EFE;
        goto_edge(3 * POLL + LATCH + 16 * HALF + HALF / 2 + 1);
        check("midframe_sclk_low", 32'(pad_if.snes_clk), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_latch", 32'(pad_if.snes_latch), 32'h0);
        check("async_rst_sclk", 32'(pad_if.snes_clk), 32'h1);
        check("async_rst_led", 32'(pad_if.led), 32'h0000);
        repeat (5) @(negedge clk);
        check("rst_hold_led", 32'(pad_if.led), 32'h0000);

        // Fresh frame with alternating data, bit 0 low.
        pattern = 16'hAAAA;
        rst = 1'b0;
        goto_edge(FRAME);
        check("alt_led_before_end", 32'(pad_if.led), 32'h0000);
        check("fresh_latch_rise", 32'(rise_last), 32'd1);
        goto_edge(FRAME + 2);
        check("alt_led", 32'(pad_if.led), 32'h5555);
        repeat (10) @(negedge clk);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
